// File: rtl/hwpe_vadd_job_ctrl.sv
// Job sequencer for the streaming vector adder: splits a job into chunks and
// drives source/sink streamer start, address and size controls per chunk.
module hwpe_vadd_job_ctrl #(
    parameter int unsigned NB_OPERANDS = 2,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned LEN_WIDTH   = 32,
    parameter int unsigned TRANS_WIDTH = 16,
    parameter int unsigned CHUNK_WORDS = 256,
    parameter int unsigned WORD_BYTES  = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              clear_i,
    input  logic                              job_start_i,
    input  logic [NB_OPERANDS*ADDR_WIDTH-1:0] job_src_addr_i,
    input  logic [ADDR_WIDTH-1:0]             job_dst_addr_i,
    input  logic [LEN_WIDTH-1:0]              job_len_i,
    input  logic [NB_OPERANDS-1:0]            src_ready_start_i,
    input  logic [NB_OPERANDS-1:0]            src_done_i,
    output logic [NB_OPERANDS-1:0]            src_req_start_o,
    output logic [NB_OPERANDS*ADDR_WIDTH-1:0] src_base_addr_o,
    input  logic                              sink_ready_start_i,
    input  logic                              sink_done_i,
    output logic                              sink_req_start_o,
    output logic [ADDR_WIDTH-1:0]             sink_base_addr_o,
    output logic [TRANS_WIDTH-1:0]            trans_size_o,
    output logic                              busy_o,
    output logic                              done_o,
    output logic [LEN_WIDTH-1:0]              chunk_cnt_o
);

    localparam int unsigned NB_STREAMERS = NB_OPERANDS + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t                                   state_q;
    logic [LEN_WIDTH-1:0]                     remaining_q;
    logic [NB_OPERANDS-1:0][ADDR_WIDTH-1:0]   src_addr_q;
    logic [ADDR_WIDTH-1:0]                    dst_addr_q;
    logic [TRANS_WIDTH-1:0]                   trans_q;
    logic [LEN_WIDTH-1:0]                     chunk_cnt_q;
    logic [NB_STREAMERS-1:0]                  sticky_q;
    logic                                     zero_job_q;

    logic                                     all_ready;
    logic                                     fire;
    logic [NB_STREAMERS-1:0]                  sticky_nxt;
    logic                                     chunk_done;
    logic [LEN_WIDTH-1:0]                     remaining_nxt;
    logic [ADDR_WIDTH-1:0]                    addr_step;

    // Size of the next chunk given the words still to move.
    function automatic logic [TRANS_WIDTH-1:0] chunk_size(input logic [LEN_WIDTH-1:0] rem);
        if (rem < LEN_WIDTH'(CHUNK_WORDS)) begin
            return TRANS_WIDTH'(rem);
        end
        return TRANS_WIDTH'(CHUNK_WORDS);
    endfunction

    always_comb begin
        all_ready     = (&src_ready_start_i) & sink_ready_start_i;
        fire          = (state_q == ST_ISSUE) && all_ready;
        sticky_nxt    = sticky_q | {sink_done_i, src_done_i};
        chunk_done    = (state_q == ST_WAIT) && (&sticky_nxt);
        remaining_nxt = remaining_q - LEN_WIDTH'(trans_q);
        addr_step     = ADDR_WIDTH'(trans_q) * ADDR_WIDTH'(WORD_BYTES);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            src_addr_q  <= '0;
            dst_addr_q  <= '0;
            trans_q     <= '0;
            chunk_cnt_q <= '0;
            sticky_q    <= '0;
            zero_job_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (job_start_i) begin
                        if (job_len_i != '0) begin
                            src_addr_q  <= job_src_addr_i;
                            dst_addr_q  <= job_dst_addr_i;
                            remaining_q <= job_len_i;
                            trans_q     <= chunk_size(job_len_i);
                            chunk_cnt_q <= '0;
                            sticky_q    <= '0;
                            zero_job_q  <= 1'b0;
                            state_q     <= ST_ISSUE;
                        end else begin
                            // Empty job completes without touching any streamer.
                            zero_job_q  <= 1'b1;
                            state_q     <= ST_DONE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (all_ready) begin
                        sticky_q <= '0;
                        state_q  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (chunk_done) begin
                        remaining_q <= remaining_nxt;
                        chunk_cnt_q <= chunk_cnt_q + LEN_WIDTH'(1);
                        for (int unsigned k = 0; k < NB_OPERANDS; k++) begin
                            src_addr_q[k] <= src_addr_q[k] + addr_step;
                        end
                        dst_addr_q  <= dst_addr_q + addr_step;
                        trans_q     <= chunk_size(remaining_nxt);
                        sticky_q    <= '0;
                        state_q     <= (remaining_nxt == '0) ? ST_DONE : ST_ISSUE;
                    end else begin
                        sticky_q    <= sticky_nxt;
                    end
                end
                ST_DONE: begin
                    zero_job_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Start requests are a one-cycle handshake qualified by the ready flags.
    assign src_req_start_o  = {NB_OPERANDS{fire}};
    assign sink_req_start_o = fire;
    assign src_base_addr_o  = src_addr_q;
    assign sink_base_addr_o = dst_addr_q;
    assign trans_size_o     = trans_q;
    assign chunk_cnt_o      = chunk_cnt_q;
    assign done_o           = (state_q == ST_DONE);
    assign busy_o           = (state_q != ST_IDLE) && !zero_job_q;

endmodule

// File: tb/tb_hwpe_vadd_job_ctrl.sv
// Directed plus randomized bench for hwpe_vadd_job_ctrl against a chunk-list
// reference model built from the job length and base addresses.
module tb_hwpe_vadd_job_ctrl;

    localparam int unsigned CW = 256;

    logic        clk;
    logic        rst;
    logic        clear;
    logic        job_start;
    logic [63:0] job_src_addr;
    logic [31:0] job_dst_addr;
    logic [31:0] job_len;
    logic [1:0]  src_ready;
    logic [1:0]  src_done;
    logic [1:0]  src_req;
    logic [63:0] src_base;
    logic        sink_ready;
    logic        sink_done;
    logic        sink_req;
    logic [31:0] sink_base;
    logic [15:0] trans_size;
    logic        busy;
    logic        done;
    logic [31:0] chunk_cnt;

    int tests = 0;
    int fails = 0;
    int req_cnt = 0;
    int consec_cnt = 0;
    logic prev_req = 1'b0;

    hwpe_vadd_job_ctrl dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .clear_i            (clear),
        .job_start_i        (job_start),
        .job_src_addr_i     (job_src_addr),
        .job_dst_addr_i     (job_dst_addr),
        .job_len_i          (job_len),
        .src_ready_start_i  (src_ready),
        .src_done_i         (src_done),
        .src_req_start_o    (src_req),
        .src_base_addr_o    (src_base),
        .sink_ready_start_i (sink_ready),
        .sink_done_i        (sink_done),
        .sink_req_start_o   (sink_req),
        .sink_base_addr_o   (sink_base),
        .trans_size_o       (trans_size),
        .busy_o             (busy),
        .done_o             (done),
        .chunk_cnt_o        (chunk_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mid-cycle request monitor: total request cycles and back-to-back requests.
    always @(negedge clk) begin
        if (sink_req === 1'b1) req_cnt <= req_cnt + 1;
        if (sink_req === 1'b1 && prev_req === 1'b1) consec_cnt <= consec_cnt + 1;
        prev_req <= sink_req;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_cnt"}, 64'(chunk_cnt), 64'd0);
        chk({tag, "_trans"}, 64'(trans_size), 64'd0);
        chk({tag, "_src"}, src_base, 64'd0);
        chk({tag, "_sink"}, 64'(sink_base), 64'd0);
        chk({tag, "_req"}, 64'({src_req, sink_req}), 64'd0);
    endtask

    // mode: 0 random done delays, 1 sink/src1/src0 staggered, 2 all together.
    // bp: cycles of sink backpressure before the first request.
    // inj: pulse job_start during the first WAIT. abort_at: chunk index to clear in.
    task automatic run_job(input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] d,
                           input logic [31:0] len, input int mode, input int bp,
                           input bit inj, input int abort_at);
        int unsigned  sizes[$];
        logic [31:0]  a0q[$];
        logic [31:0]  a1q[$];
        logic [31:0]  dq[$];
        longint unsigned rem;
        logic [31:0]  a0, a1, ad;
        int base_req;
        int waited;
        int dl0, dl1, dls, maxd;

        rem = len; a0 = s0; a1 = s1; ad = d;
        while (rem > 0) begin
            int unsigned sz;
            sz = (rem < CW) ? int'(rem) : CW;
            sizes.push_back(sz); a0q.push_back(a0); a1q.push_back(a1); dq.push_back(ad);
            a0 += sz * 4; a1 += sz * 4; ad += sz * 4;
            rem -= sz;
        end

        base_req     = req_cnt;
        job_src_addr = {s1, s0};
        job_dst_addr = d;
        job_len      = len;
        job_start    = 1'b1;
        settle();
        chk("idle_busy", 64'(busy), 64'd0);
        tick();
        job_start = 1'b0;

        if (len == 0) begin
            settle();
            chk("zero_done", 64'(done), 64'd1);
            chk("zero_busy", 64'(busy), 64'd0);
            chk("zero_req", 64'({src_req, sink_req}), 64'd0);
            tick();
            settle();
            chk("zero_done_end", 64'(done), 64'd0);
            chk("zero_busy_end", 64'(busy), 64'd0);
            #10;
            chk("zero_req_cnt", 64'(req_cnt - base_req), 64'd0);
            return;
        end

        for (int i = 0; i < sizes.size(); i++) begin
            if (i == 0 && bp > 0) begin
                sink_ready = 1'b0;
                for (int c = 0; c < bp; c++) begin
                    src_done  = 2'b11;
                    sink_done = 1'b1;
                    settle();
                    chk("bp_noreq", 64'({src_req, sink_req}), 64'd0);
                    tick();
                end
                src_done   = 2'b00;
                sink_done  = 1'b0;
                sink_ready = 1'b1;
            end

            waited = 0;
            settle();
            while (sink_req !== 1'b1 && waited < 40) begin
                tick();
                settle();
                waited++;
            end
            chk("req_latency", 64'(waited), 64'd0);
            if (waited >= 40) return;
            chk("req_vec", 64'({src_req, sink_req}), 64'b111);
            chk("trans", 64'(trans_size), 64'(sizes[i]));
            chk("src0_addr", 64'(src_base[31:0]), 64'(a0q[i]));
            chk("src1_addr", 64'(src_base[63:32]), 64'(a1q[i]));
            chk("sink_addr", 64'(sink_base), 64'(dq[i]));
            chk("cnt_at_req", 64'(chunk_cnt), 64'(i));
            chk("busy_at_req", 64'(busy), 64'd1);
            tick();

            if (inj && i == 0) begin
                job_start    = 1'b1;
                job_len      = 32'd0;
                job_src_addr = {$urandom(), $urandom()};
                job_dst_addr = $urandom();
            end

            if (abort_at == i) begin
                src_done = 2'b01;
                clear    = 1'b1;
                tick();
                clear    = 1'b0;
                src_done = 2'b00;
                settle();
                check_cleared("clear");
                for (int c = 0; c < 4; c++) begin
                    src_done  = 2'b11;
                    sink_done = 1'b1;
                    settle();
                    chk("clear_no_done", 64'(done), 64'd0);
                    chk("clear_idle", 64'(busy), 64'd0);
                    tick();
                end
                src_done  = 2'b00;
                sink_done = 1'b0;
                return;
            end

            case (mode)
                1: begin dls = 0; dl1 = 1; dl0 = 3; end
                2: begin dls = 0; dl1 = 0; dl0 = 0; end
                default: begin
                    dl0 = int'($urandom_range(3, 0));
                    dl1 = int'($urandom_range(3, 0));
                    dls = int'($urandom_range(3, 0));
                end
            endcase
            maxd = dl0;
            if (dl1 > maxd) maxd = dl1;
            if (dls > maxd) maxd = dls;

            for (int dd = 0; dd <= maxd; dd++) begin
                src_done[0] = (dl0 == dd);
                src_done[1] = (dl1 == dd);
                sink_done   = (dls == dd);
                settle();
                chk("wait_cnt_hold", 64'(chunk_cnt), 64'(i));
                chk("wait_no_req", 64'({src_req, sink_req}), 64'd0);
                chk("wait_no_done", 64'(done), 64'd0);
                chk("wait_trans_stable", 64'(trans_size), 64'(sizes[i]));
                tick();
                job_start = 1'b0;
                src_done  = 2'b00;
                sink_done = 1'b0;
            end
        end

        settle();
        chk("job_done", 64'(done), 64'd1);
        chk("job_cnt", 64'(chunk_cnt), 64'(sizes.size()));
        chk("job_busy_in_done", 64'(busy), 64'd1);
        tick();
        settle();
        chk("job_done_end", 64'(done), 64'd0);
        chk("job_idle", 64'(busy), 64'd0);
        #10;
        chk("req_count", 64'(req_cnt - base_req), 64'(sizes.size()));
        chk("no_back_to_back", 64'(consec_cnt), 64'd0);
    endtask

    initial begin
        rst          = 1'b1;
        clear        = 1'b0;
        job_start    = 1'b0;
        job_src_addr = '0;
        job_dst_addr = '0;
        job_len      = '0;
        src_ready    = 2'b11;
        src_done     = 2'b00;
        sink_ready   = 1'b1;
        sink_done    = 1'b0;
        tick(); tick(); tick();
        settle();
        check_cleared("reset");
        rst = 1'b0;
        tick();

        run_job(32'h1000, 32'h2000, 32'h3000, 32'd10, 2, 0, 1'b0, -1);
        run_job(32'h1000, 32'h2000, 32'h3000, 32'd600, 0, 0, 1'b0, -1);
        run_job(32'h4000, 32'h8000, 32'hC000, 32'd300, 1, 0, 1'b0, -1);
        run_job(32'h4000, 32'h8000, 32'hC000, 32'd20, 1, 5, 1'b0, -1);
        run_job(32'h1000, 32'h2000, 32'h3000, 32'd0, 0, 0, 1'b0, -1);
        run_job(32'h5000, 32'h6000, 32'h7000, 32'd300, 0, 0, 1'b1, -1);
        run_job(32'h1000, 32'h2000, 32'h3000, 32'd600, 0, 0, 1'b0, 1);
        run_job(32'h100, 32'h200, 32'hFFFF_FC00, 32'd512, 2, 0, 1'b0, -1);

        for (int r = 0; r < 6; r++) begin
            logic [31:0] rlen;
            rlen = 32'($urandom_range(700, 1));
            run_job($urandom() & 32'hFFFF_FFFC, $urandom() & 32'hFFFF_FFFC,
                    $urandom() & 32'hFFFF_FFFC, rlen, 0, 0, 1'b0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
